// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register offsets, STATUS bit positions and TX/RX FSM states for uart_regs
package uart_pkg;
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_TX_DATA = 2'd1;
  localparam logic [1:0] REG_RX_DATA = 2'd2;
  localparam logic [1:0] REG_DIVISOR = 2'd3;

  localparam int ST_TX_READY    = 0;
  localparam int ST_RX_VALID    = 1;
  localparam int ST_RX_OVERRUN  = 2;
  localparam int ST_FRAMING_ERR = 3;
  localparam int ST_TX_BUSY     = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO; a pop in the same cycle frees room for a push while full
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_pop, do_push;

  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/uart_regs.sv
// rtl/uart_regs.sv - memory-mapped 8N1 UART with TX FIFO and registered read data
// UART_RX_FIFO_EN selects a uart_fifo RX buffer; otherwise RX holds a single byte.
module uart_regs
  import uart_pkg::*;
#(
  parameter logic [6:0]  BASE_INDEX      = 7'd0,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd433,
  parameter int          TX_FIFO_DEPTH   = 4,
  parameter int          RX_FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic        uart_tx,
  input  logic        uart_rx
);
  if (TX_FIFO_DEPTH < 2 || (TX_FIFO_DEPTH & (TX_FIFO_DEPTH - 1)) != 0 ||
      RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_regs: FIFO depths must be powers of two >= 2");
  end

  logic [6:0]  offset, prev_index;
  logic        mapped, first_read, rd_hit, wr_hit, prev_read;
  logic [15:0] divisor, rd_data, status_word;
  logic        rx_overrun, framing_err, status_clr;
  logic        tx_push, tx_pop, tx_full, tx_empty, tx_tick, tx_busy;
  logic [7:0]  tx_data, tx_shift, rx_shift, rx_byte;
  logic [15:0] tx_baud, tx_div, rx_baud, rx_div;
  logic [2:0]  tx_bit, rx_bit;
  logic        rx_s1, rx_s2, rx_s3, rx_tick, rx_done, rx_push, rx_pop;
  logic        rx_valid, rx_full, frame_set, overrun_set;
  tx_state_t   tx_state;
  rx_state_t   rx_state;

  assign offset     = register_index - BASE_INDEX;
  assign mapped     = (register_index >= BASE_INDEX) && (offset[6:2] == 5'd0);
  // a read held at the same index is one access, so side effects fire once
  assign first_read = register_read && !(prev_read && prev_index == register_index);
  assign rd_hit     = first_read && mapped;
  assign wr_hit     = register_write && mapped;
  assign tx_busy    = (tx_state != TX_IDLE) || !tx_empty;

  always_comb begin
    tx_push     = wr_hit && offset[1:0] == REG_TX_DATA;
    status_clr  = wr_hit && offset[1:0] == REG_STATUS;
    rx_pop      = rd_hit && offset[1:0] == REG_RX_DATA && rx_valid;
    tx_tick     = tx_baud == tx_div;
    tx_pop      = !tx_empty && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_tick));
    rx_tick     = (rx_state == RX_START) ? (rx_baud == (rx_div >> 1)) : (rx_baud == rx_div);
    rx_done     = rx_state == RX_STOP && rx_tick;
    rx_push     = rx_done && rx_s2;
    frame_set   = rx_done && !rx_s2;
    overrun_set = rx_push && rx_full && !rx_pop;
  end

  always_comb begin
    status_word                 = '0;
    status_word[ST_TX_READY]    = !tx_full;
    status_word[ST_RX_VALID]    = rx_valid;
    status_word[ST_RX_OVERRUN]  = rx_overrun;
    status_word[ST_FRAMING_ERR] = framing_err;
    status_word[ST_TX_BUSY]     = tx_busy;
    rd_data = '0;
    if (mapped) begin
      case (offset[1:0])
        REG_STATUS:  rd_data = status_word;
        REG_RX_DATA: if (rx_valid) rd_data = {7'd0, 1'b1, rx_byte};
        REG_DIVISOR: rd_data = divisor;
        default:     rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_read           <= 1'b0;
      prev_index          <= '0;
      register_read_value <= '0;
      divisor             <= DEFAULT_DIVISOR;
      rx_overrun          <= 1'b0;
      framing_err         <= 1'b0;
    end else begin
      prev_read  <= register_read;
      prev_index <= register_index;
      if (first_read) register_read_value <= rd_data;
      if (wr_hit && offset[1:0] == REG_DIVISOR) divisor <= register_write_value;
      // hardware set wins over a same-cycle software clear
      rx_overrun  <= (rx_overrun && !(status_clr && register_write_value[ST_RX_OVERRUN])) || overrun_set;
      framing_err <= (framing_err && !(status_clr && register_write_value[ST_FRAMING_ERR])) || frame_set;
    end
  end

  uart_fifo #(.DEPTH(TX_FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(tx_push), .push_data(register_write_value[7:0]),
    .pop(tx_pop), .pop_data(tx_data), .full(tx_full), .empty(tx_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_baud  <= '0;
      tx_div   <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
      uart_tx  <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= TX_START;
      tx_shift <= tx_data;
      tx_div   <= divisor;
      tx_baud  <= '0;
      uart_tx  <= 1'b0;
    end else begin
      tx_baud <= tx_tick ? 16'd0 : tx_baud + 16'd1;
      case (tx_state)
        TX_IDLE: tx_baud <= '0;
        TX_START: if (tx_tick) begin
          uart_tx  <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
          tx_bit   <= '0;
          tx_state <= TX_DATA;
        end
        TX_DATA: if (tx_tick) begin
          if (tx_bit == 3'd7) begin
            uart_tx  <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            uart_tx  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + 3'd1;
          end
        end
        TX_STOP: if (tx_tick) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {rx_s1, rx_s2, rx_s3} <= 3'b111;
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_div   <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      {rx_s1, rx_s2, rx_s3} <= {uart_rx, rx_s1, rx_s2};
      rx_baud <= rx_tick ? 16'd0 : rx_baud + 16'd1;
      case (rx_state)
        RX_IDLE: begin
          rx_baud <= '0;
          if (rx_s3 && !rx_s2) begin
            rx_state <= RX_START;
            rx_div   <= divisor;
          end
        end
        RX_START: if (rx_tick) begin
          rx_bit   <= '0;
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_tick) begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
        end
        RX_STOP: if (rx_tick) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  logic rx_empty;
  uart_fifo #(.DEPTH(RX_FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push), .push_data(rx_shift),
    .pop(rx_pop), .pop_data(rx_byte), .full(rx_full), .empty(rx_empty)
  );
  assign rx_valid = !rx_empty;
`else
  logic [7:0] rx_hold;
  logic       rx_hold_valid;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_hold       <= '0;
      rx_hold_valid <= 1'b0;
    end else if (rx_push && (!rx_hold_valid || rx_pop)) begin
      rx_hold       <= rx_shift;
      rx_hold_valid <= 1'b1;
    end else if (rx_pop) begin
      rx_hold_valid <= 1'b0;
    end
  end
  assign rx_byte  = rx_hold;
  assign rx_valid = rx_hold_valid;
  assign rx_full  = rx_hold_valid;
`endif
endmodule

// File: tb/tb_uart_regs.sv
// tb/tb_uart_regs.sv - directed self-checking bench for uart_regs
module tb_uart_regs;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  register_index = '0;
  logic        register_read = 1'b0;
  logic        register_write = 1'b0;
  logic [15:0] register_write_value = '0;
  logic [15:0] register_read_value;
  logic        uart_tx;
  logic        uart_rx = 1'b1;
  int          tests = 0;
  int          fails = 0;

  localparam logic [6:0] I_STATUS = 7'd0, I_TX = 7'd1, I_RX = 7'd2, I_DIV = 7'd3;

  always #5 clk = ~clk;

  uart_regs dut (
    .clk(clk), .reset_n(reset_n), .register_index(register_index),
    .register_read(register_read), .register_write(register_write),
    .register_write_value(register_write_value), .register_read_value(register_read_value),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  task automatic do_write(input logic [6:0] idx, input logic [15:0] val);
    @(negedge clk);
    register_index = idx; register_write_value = val; register_write = 1'b1;
    @(negedge clk);
    register_write = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] idx, output logic [15:0] val);
    @(negedge clk);
    register_index = idx; register_read = 1'b1;
    @(negedge clk);
    register_read = 1'b0;
    val = register_read_value;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (4) @(negedge clk);
    end
    uart_rx = stop;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    repeat (3) @(negedge clk);
    tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
    tests++; if (register_read_value !== 16'h0000) begin fails++; $display("FAIL reset_rdval: got %h expected 0000", register_read_value); end
    reset_n = 1'b1;
    do_read(I_STATUS, rd);
    tests++; if (rd !== 16'h0001) begin fails++; $display("FAIL reset_status: got %h expected 0001", rd); end
    do_read(I_DIV, rd);
    tests++; if (rd !== 16'd433) begin fails++; $display("FAIL reset_divisor: got %h expected 01b1", rd); end
    do_read(7'd10, rd);
    tests++; if (rd !== 16'h0000) begin fails++; $display("FAIL unmapped_read: got %h expected 0000", rd); end
    do_write(I_DIV, 16'd3);
    do_read(I_DIV, rd);
    tests++; if (rd !== 16'd3) begin fails++; $display("FAIL divisor_write: got %h expected 0003", rd); end
    do_read(I_TX, rd);
    tests++; if (rd !== 16'h0000) begin fails++; $display("FAIL txdata_read: got %h expected 0000", rd); end
  endtask

  task automatic test_tx_single();
    logic [9:0]  frame;
    logic [15:0] rd;
    frame = {1'b1, 8'hA5, 1'b0};
    do_write(I_TX, 16'h00A5);
    tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL tx_pre_start: got %b expected 1", uart_tx); end
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      tests++;
      if (uart_tx !== frame[c/4]) begin
        fails++; $display("FAIL tx_a5_bit cycle %0d: got %b expected %b", c, uart_tx, frame[c/4]);
      end
      @(negedge clk);
    end
    tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL tx_idle_after: got %b expected 1", uart_tx); end
    do_read(I_STATUS, rd);
    tests++; if (rd !== 16'h0001) begin fails++; $display("FAIL tx_status_idle: got %h expected 0001", rd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [5] = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h81};
    logic [15:0] rd;
    logic        exp;
    int          bp;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      register_index = I_TX; register_write = 1'b1;
      register_write_value = (i < 5) ? {8'h00, bytes[i]} : 16'h00FF;
    end
    @(negedge clk);
    register_write = 1'b0;
    register_index = I_STATUS; register_read = 1'b1;
    @(negedge clk);
    register_read = 1'b0;
    rd = register_read_value;
    tests++; if (rd !== 16'h0010) begin fails++; $display("FAIL b2b_status_full: got %h expected 0010", rd); end
    for (int c = 5; c < 240; c++) begin
      bp = (c % 40) / 4;
      if (c >= 200)     exp = 1'b1;
      else if (bp == 0) exp = 1'b0;
      else if (bp == 9) exp = 1'b1;
      else              exp = bytes[c/40][bp-1];
      tests++;
      if (uart_tx !== exp) begin
        fails++; $display("FAIL b2b_line cycle %0d: got %b expected %b", c, uart_tx, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rx();
    logic [15:0] rd;
    send_rx(8'h3C, 1'b1);
    do_read(I_STATUS, rd);
    tests++; if (rd !== 16'h0003) begin fails++; $display("FAIL rx_status_valid: got %h expected 0003", rd); end
    @(negedge clk);
    register_index = I_RX; register_read = 1'b1;
    @(negedge clk);
    tests++; if (register_read_value !== 16'h013C) begin fails++; $display("FAIL rx_data: got %h expected 013c", register_read_value); end
    repeat (2) @(negedge clk);
    tests++; if (register_read_value !== 16'h013C) begin fails++; $display("FAIL rx_held_read: got %h expected 013c", register_read_value); end
    register_read = 1'b0;
    do_read(I_RX, rd);
    tests++; if (rd !== 16'h0000) begin fails++; $display("FAIL rx_empty_read: got %h expected 0000", rd); end
    do_read(I_STATUS, rd);
    tests++; if (rd !== 16'h0001) begin fails++; $display("FAIL rx_status_empty: got %h expected 0001", rd); end
  endtask

  task automatic test_framing();
    logic [15:0] rd;
    send_rx(8'h55, 1'b0);
    do_read(I_STATUS, rd);
    tests++; if (rd !== 16'h0009) begin fails++; $display("FAIL framing_set: got %h expected 0009", rd); end
    do_write(I_STATUS, 16'h0008);
    do_read(I_STATUS, rd);
    tests++; if (rd !== 16'h0001) begin fails++; $display("FAIL framing_clear: got %h expected 0001", rd); end
  endtask

  task automatic test_overrun();
    logic [15:0] rd;
    int          n;
`ifdef UART_RX_FIFO_EN
    n = 9;
`else
    n = 2;
`endif
    for (int i = 1; i <= n; i++) send_rx(8'(i * 8'h11), 1'b1);
    do_read(I_STATUS, rd);
    tests++; if (rd !== 16'h0007) begin fails++; $display("FAIL overrun_status: got %h expected 0007", rd); end
    do_read(I_RX, rd);
    tests++; if (rd !== 16'h0111) begin fails++; $display("FAIL overrun_first_byte: got %h expected 0111", rd); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] rd;
    do_write(I_TX, 16'h0000);
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL midreset_tx: got %b expected 1", uart_tx); end
    tests++; if (register_read_value !== 16'h0000) begin fails++; $display("FAIL midreset_rdval: got %h expected 0000", register_read_value); end
    reset_n = 1'b1; uart_rx = 1'b1;
    do_read(I_STATUS, rd);
    tests++; if (rd !== 16'h0001) begin fails++; $display("FAIL midreset_status: got %h expected 0001", rd); end
    do_read(I_DIV, rd);
    tests++; if (rd !== 16'd433) begin fails++; $display("FAIL midreset_divisor: got %h expected 01b1", rd); end
    repeat (50) @(negedge clk);
    tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL midreset_tx_idle: got %b expected 1", uart_tx); end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx();
    test_framing();
    test_overrun();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
